// File: rtl/mem_access_ctrl.sv
// Memory-access controller between the MIC-1 datapath and a dual-port main
// memory. Port A serves MAR/MDR data reads and writes, port B serves PC/MBR
// instruction fetches. Single-cycle datapath strobes become memory enables,
// registered read data is captured into MDR/MBR, and illegal command
// sequences raise a one-cycle cmd_err pulse.
module mem_access_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 9,
  parameter int MBR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd,
  input  logic              wr,
  input  logic              fetch,
  input  logic [ADDR_W-1:0] mar,
  input  logic [ADDR_W-1:0] pc,
  input  logic              mdr_load,
  input  logic [DATA_W-1:0] mdr_d,
  output logic [DATA_W-1:0] mdr,
  output logic [DATA_W-1:0] mbr_u,
  output logic [DATA_W-1:0] mbr_s,
  output logic              mdr_valid,
  output logic              mbr_valid,
  output logic              busy_a,
  output logic              busy_b,
  output logic              cmd_err,
  output logic              mem_wen_a,
  output logic              mem_ren_a,
  output logic [ADDR_W-1:0] mem_addr_a,
  output logic [DATA_W-1:0] mem_wdata_a,
  input  logic [DATA_W-1:0] mem_rdata_a,
  output logic              mem_ren_b,
  output logic [ADDR_W-1:0] mem_addr_b,
  input  logic [DATA_W-1:0] mem_rdata_b
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t state_a;
  state_t state_b;

  logic [MBR_W-1:0] mbr_p2;

  logic acc_a_p0;
  logic acc_b_p0;
  logic rd_go_p0;
  logic wr_go_p0;
  logic fetch_go_p0;
  logic err_p0;

  // Upper port-B data bits carry no instruction-byte information.
  logic unused_rdata_b;

  function automatic logic [DATA_W-1:0] zext_mbr(input logic [MBR_W-1:0] v);
    return {{(DATA_W-MBR_W){1'b0}}, v};
  endfunction

  function automatic logic signed [DATA_W-1:0] sext_mbr(input logic signed [MBR_W-1:0] v);
    return {{(DATA_W-MBR_W){v[MBR_W-1]}}, v};
  endfunction

  // p0: issue stage -- a port accepts a command in IDLE or CAPTURE, never while
  // its read is still in flight. Write beats read when both strobes arrive.
  always_comb begin
    acc_a_p0    = (state_a != RD_WAIT);
    acc_b_p0    = (state_b != RD_WAIT);
    wr_go_p0    = wr & acc_a_p0;
    rd_go_p0    = rd & ~wr & acc_a_p0;
    fetch_go_p0 = fetch & acc_b_p0;
    err_p0      = (rd & wr & acc_a_p0)
                | (~acc_a_p0 & (rd | wr | mdr_load))
                | (~acc_b_p0 & fetch);
  end

  assign mem_wen_a   = rst_n & wr_go_p0;
  assign mem_ren_a   = rst_n & rd_go_p0;
  assign mem_ren_b   = rst_n & fetch_go_p0;
  assign mem_addr_a  = mar;
  assign mem_wdata_a = mdr;
  assign mem_addr_b  = pc;

  assign mbr_u = zext_mbr(mbr_p2);
  assign mbr_s = sext_mbr(mbr_p2);

  assign unused_rdata_b = ^mem_rdata_b[DATA_W-1:MBR_W];

  // p0 -> p1 -> p2: port-A sequencing, busy during the wait cycle, valid in capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_a   <= IDLE;
      busy_a    <= 1'b0;
      mdr_valid <= 1'b0;
    end else begin
      busy_a    <= rd_go_p0;
      mdr_valid <= (state_a == RD_WAIT);
      case (state_a)
        IDLE, CAPTURE: state_a <= rd_go_p0 ? RD_WAIT : IDLE;
        RD_WAIT:       state_a <= CAPTURE;
        default:       state_a <= IDLE;
      endcase
    end
  end

  // p0 -> p1 -> p2: port-B sequencing, same shape as port A driven by fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_b   <= IDLE;
      busy_b    <= 1'b0;
      mbr_valid <= 1'b0;
    end else begin
      busy_b    <= fetch_go_p0;
      mbr_valid <= (state_b == RD_WAIT);
      case (state_b)
        IDLE, CAPTURE: state_b <= fetch_go_p0 ? RD_WAIT : IDLE;
        RD_WAIT:       state_b <= CAPTURE;
        default:       state_b <= IDLE;
      endcase
    end
  end

  // p1 -> p2: MDR capture; read data wins over a datapath load on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdr <= '0;
    end else if (state_a == RD_WAIT) begin
      mdr <= mem_rdata_a;
    end else if (mdr_load) begin
      mdr <= mdr_d;
    end
  end

  // p1 -> p2: MBR capture of the instruction byte from port-B read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mbr_p2 <= '0;
    end else if (state_b == RD_WAIT) begin
      mbr_p2 <= mem_rdata_b[MBR_W-1:0];
    end
  end

  // p0 -> p1: one error pulse per offending cycle, however many rules it broke.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_err <= 1'b0;
    end else begin
      cmd_err <= err_p0;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus a randomized
// run checked every cycle against a cycle-count reference model.
module tb_mem_access_ctrl;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 9;
  localparam int MBR_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rd = 1'b0, wr = 1'b0, fetch = 1'b0, mdr_load = 1'b0;
  logic [ADDR_W-1:0] mar = '0, pc = '0;
  logic [DATA_W-1:0] mdr_d = '0;
  logic [DATA_W-1:0] mdr, mbr_u, mbr_s;
  logic              mdr_valid, mbr_valid, busy_a, busy_b, cmd_err;
  logic              mem_wen_a, mem_ren_a, mem_ren_b;
  logic [ADDR_W-1:0] mem_addr_a, mem_addr_b;
  logic [DATA_W-1:0] mem_wdata_a, mem_rdata_a, mem_rdata_b;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mem     [0:511];
  logic [DATA_W-1:0] ref_mem [0:511];
  logic              fill_req = 1'b0, pre_we = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [DATA_W-1:0] pre_data = '0;

  mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MBR_W(MBR_W)) dut (
    .clk(clk), .rst_n(rst_n), .rd(rd), .wr(wr), .fetch(fetch),
    .mar(mar), .pc(pc), .mdr_load(mdr_load), .mdr_d(mdr_d),
    .mdr(mdr), .mbr_u(mbr_u), .mbr_s(mbr_s),
    .mdr_valid(mdr_valid), .mbr_valid(mbr_valid),
    .busy_a(busy_a), .busy_b(busy_b), .cmd_err(cmd_err),
    .mem_wen_a(mem_wen_a), .mem_ren_a(mem_ren_a), .mem_addr_a(mem_addr_a),
    .mem_wdata_a(mem_wdata_a), .mem_rdata_a(mem_rdata_a),
    .mem_ren_b(mem_ren_b), .mem_addr_b(mem_addr_b), .mem_rdata_b(mem_rdata_b)
  );

  always #5 clk = ~clk;

  // Dual-port memory with registered reads; read data is junk when not enabled.
  always @(posedge clk) begin
    if (fill_req) for (int i = 0; i < 512; i++) mem[i] <= 9'(i * 7 + 3);
    if (pre_we) mem[pre_addr] <= pre_data;
    if (mem_wen_a) mem[mem_addr_a] <= mem_wdata_a;
    mem_rdata_a <= mem_ren_a ? mem[mem_addr_a] : 9'($urandom);
    mem_rdata_b <= mem_ren_b ? mem[mem_addr_b] : 9'($urandom);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd = 1'b0; wr = 1'b0; fetch = 1'b0; mdr_load = 1'b0;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    tick(); idle();
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rd = 1'b1; wr = 1'b1; fetch = 1'b1; mar = 9'd3; pc = 9'd4;
    mdr_load = 1'b1; mdr_d = 9'h155;
    #2;
    checks++;
    if ({mem_wen_a, mem_ren_a, mem_ren_b} !== 3'b000) begin
      errors++; $display("FAIL reset_enables: got %b expected 000", {mem_wen_a, mem_ren_a, mem_ren_b});
    end
    tick();
    checks++;
    if ({mdr, mbr_u, mdr_valid, mbr_valid, busy_a, busy_b, cmd_err} !== 23'd0) begin
      errors++; $display("FAIL reset_state: got %h expected 0",
                         {mdr, mbr_u, mdr_valid, mbr_valid, busy_a, busy_b, cmd_err});
    end
    idle();
    fill_req = 1'b1;
    tick();
    fill_req = 1'b0;
    for (int i = 0; i < 512; i++) ref_mem[i] = 9'(i * 7 + 3);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_read();
    preload(9'd3, 9'h1A5);
    tick(); rd = 1'b1; mar = 9'd3;
    @(negedge clk);
    checks++;
    if ({mem_ren_a, mem_wen_a, mem_addr_a} !== {1'b1, 1'b0, 9'd3}) begin
      errors++; $display("FAIL read_issue: got %h expected %h", {mem_ren_a, mem_wen_a, mem_addr_a}, {1'b1, 1'b0, 9'd3});
    end
    tick(); idle();
    @(negedge clk);
    checks++;
    if ({busy_a, mdr_valid} !== 2'b10) begin
      errors++; $display("FAIL read_busy: got %b expected 10", {busy_a, mdr_valid});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({mdr, mdr_valid, busy_a} !== {9'h1A5, 1'b1, 1'b0}) begin
      errors++; $display("FAIL read_data: got %h expected %h", {mdr, mdr_valid, busy_a}, {9'h1A5, 1'b1, 1'b0});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({mdr_valid, cmd_err} !== 2'b00) begin
      errors++; $display("FAIL read_after: got %b expected 00", {mdr_valid, cmd_err});
    end
  endtask

  task automatic test_fetch();
    logic [DATA_W-1:0] vals [2];
    logic [DATA_W-1:0] exp_s [2];
    vals[0] = 9'h0F0; exp_s[0] = 9'h1F0;
    vals[1] = 9'h07F; exp_s[1] = 9'h07F;
    for (int k = 0; k < 2; k++) begin
      preload(9'd5, vals[k]);
      tick(); fetch = 1'b1; pc = 9'd5;
      @(negedge clk);
      checks++;
      if ({mem_ren_b, mem_addr_b} !== {1'b1, 9'd5}) begin
        errors++; $display("FAIL fetch_issue%0d: got %h expected %h", k, {mem_ren_b, mem_addr_b}, {1'b1, 9'd5});
      end
      tick(); idle();
      @(negedge clk);
      checks++;
      if ({busy_b, mbr_valid} !== 2'b10) begin
        errors++; $display("FAIL fetch_busy%0d: got %b expected 10", k, {busy_b, mbr_valid});
      end
      tick();
      @(negedge clk);
      checks++;
      if ({mbr_valid, mbr_u, mbr_s} !== {1'b1, vals[k], exp_s[k]}) begin
        errors++; $display("FAIL fetch_ext%0d: got %h expected %h", k, {mbr_valid, mbr_u, mbr_s}, {1'b1, vals[k], exp_s[k]});
      end
    end
  endtask

  task automatic test_write_read();
    tick(); idle(); mdr_load = 1'b1; mdr_d = 9'h123;
    tick(); idle(); wr = 1'b1; mar = 9'd7;
    @(negedge clk);
    checks++;
    if ({mem_wen_a, mem_ren_a, mem_addr_a, mem_wdata_a} !== {1'b1, 1'b0, 9'd7, 9'h123}) begin
      errors++; $display("FAIL write_issue: got %h expected %h",
                         {mem_wen_a, mem_ren_a, mem_addr_a, mem_wdata_a}, {1'b1, 1'b0, 9'd7, 9'h123});
    end
    ref_mem[7] = 9'h123;
    tick(); idle(); rd = 1'b1; mar = 9'd7; mdr_load = 1'b1; mdr_d = 9'h0AA;
    @(negedge clk);
    checks++;
    if (mem_ren_a !== 1'b1) begin
      errors++; $display("FAIL wr_rd_issue: got %b expected 1", mem_ren_a);
    end
    tick(); idle();
    @(negedge clk);
    checks++;
    if ({mdr, busy_a} !== {9'h0AA, 1'b1}) begin
      errors++; $display("FAIL wr_rd_load: got %h expected %h", {mdr, busy_a}, {9'h0AA, 1'b1});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({mdr, mdr_valid} !== {9'h123, 1'b1}) begin
      errors++; $display("FAIL wr_rd_back: got %h expected %h", {mdr, mdr_valid}, {9'h123, 1'b1});
    end
  endtask

  task automatic test_collisions();
    // rd and wr together: write wins, read dropped, error next cycle
    tick(); idle(); rd = 1'b1; wr = 1'b1; mar = 9'd9;
    @(negedge clk);
    checks++;
    if ({mem_wen_a, mem_ren_a, mem_wdata_a} !== {2'b10, 9'h123}) begin
      errors++; $display("FAIL rdwr_enables: got %h expected %h", {mem_wen_a, mem_ren_a, mem_wdata_a}, {2'b10, 9'h123});
    end
    ref_mem[9] = 9'h123;
    tick(); idle();
    @(negedge clk);
    checks++;
    if ({cmd_err, busy_a} !== 2'b10) begin
      errors++; $display("FAIL rdwr_err: got %b expected 10", {cmd_err, busy_a});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({cmd_err, mdr_valid, mem[9]} !== {2'b00, 9'h123}) begin
      errors++; $display("FAIL rdwr_after: got %h expected %h", {cmd_err, mdr_valid, mem[9]}, {2'b00, 9'h123});
    end
    // commands while a read is in flight are ignored
    tick(); rd = 1'b1; mar = 9'd3;
    tick(); idle(); rd = 1'b1; wr = 1'b1; mar = 9'd5;
    @(negedge clk);
    checks++;
    if ({mem_wen_a, mem_ren_a, busy_a} !== 3'b001) begin
      errors++; $display("FAIL wait_ignore: got %b expected 001", {mem_wen_a, mem_ren_a, busy_a});
    end
    tick(); idle();
    @(negedge clk);
    checks++;
    if ({cmd_err, mdr_valid, mdr} !== {2'b11, 9'h1A5}) begin
      errors++; $display("FAIL wait_err: got %h expected %h", {cmd_err, mdr_valid, mdr}, {2'b11, 9'h1A5});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({cmd_err, mdr_valid, busy_a} !== 3'b000) begin
      errors++; $display("FAIL wait_after: got %b expected 000", {cmd_err, mdr_valid, busy_a});
    end
    // mdr_load on the capture edge loses to the read data
    tick(); rd = 1'b1; mar = 9'd5;
    tick(); idle(); mdr_load = 1'b1; mdr_d = 9'h055;
    tick(); idle();
    @(negedge clk);
    checks++;
    if ({mdr, cmd_err} !== {9'h07F, 1'b1}) begin
      errors++; $display("FAIL load_capture: got %h expected %h", {mdr, cmd_err}, {9'h07F, 1'b1});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({mdr, cmd_err} !== {9'h07F, 1'b0}) begin
      errors++; $display("FAIL load_after: got %h expected %h", {mdr, cmd_err}, {9'h07F, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] addrs [4];
    logic e_ren;
    tick(); idle(); rd = 1'b1; mar = 9'd3; fetch = 1'b1; pc = 9'd5;
    @(negedge clk);
    checks++;
    if ({mem_ren_a, mem_ren_b} !== 2'b11) begin
      errors++; $display("FAIL conc_issue: got %b expected 11", {mem_ren_a, mem_ren_b});
    end
    tick(); idle();
    @(negedge clk);
    checks++;
    if ({busy_a, busy_b} !== 2'b11) begin
      errors++; $display("FAIL conc_busy: got %b expected 11", {busy_a, busy_b});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({mdr_valid, mbr_valid, mdr, mbr_u} !== {2'b11, ref_mem[3], ref_mem[5]}) begin
      errors++; $display("FAIL conc_data: got %h expected %h", {mdr_valid, mbr_valid, mdr, mbr_u}, {2'b11, ref_mem[3], ref_mem[5]});
    end
    addrs[0] = 9'd3; addrs[1] = 9'd5; addrs[2] = 9'd7; addrs[3] = 9'd9;
    tick(); idle(); rd = 1'b1; mar = addrs[0];
    for (int k = 1; k <= 4; k++) begin
      tick(); idle();
      @(negedge clk);
      checks++;
      if ({busy_a, cmd_err} !== 2'b10) begin
        errors++; $display("FAIL b2b_busy%0d: got %b expected 10", k, {busy_a, cmd_err});
      end
      tick(); idle();
      e_ren = (k < 4);
      if (e_ren) begin rd = 1'b1; mar = addrs[k]; end
      @(negedge clk);
      checks++;
      if ({mdr_valid, mdr, cmd_err, mem_ren_a} !== {1'b1, ref_mem[addrs[k-1]], 1'b0, e_ren}) begin
        errors++; $display("FAIL b2b_cap%0d: got %h expected %h", k,
                           {mdr_valid, mdr, cmd_err, mem_ren_a}, {1'b1, ref_mem[addrs[k-1]], 1'b0, e_ren});
      end
    end
  endtask

  task automatic test_reset_mid();
    tick(); idle(); rd = 1'b1; mar = 9'd3; fetch = 1'b1; pc = 9'd5;
    tick(); idle(); rd = 1'b1; fetch = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_a, busy_b, mdr, mbr_u, mdr_valid, mbr_valid, cmd_err, mem_wen_a, mem_ren_a, mem_ren_b} !== 26'd0) begin
      errors++; $display("FAIL midrst_clear: got %h expected 0",
                         {busy_a, busy_b, mdr, mbr_u, mdr_valid, mbr_valid, cmd_err, mem_wen_a, mem_ren_a, mem_ren_b});
    end
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if ({mdr_valid, mbr_valid, cmd_err, mdr} !== 12'd0) begin
      errors++; $display("FAIL midrst_novalid: got %h expected 0", {mdr_valid, mbr_valid, cmd_err, mdr});
    end
    tick(); rd = 1'b1; mar = 9'd3;
    @(negedge clk);
    checks++;
    if (mem_ren_a !== 1'b1) begin
      errors++; $display("FAIL midrst_issue: got %b expected 1", mem_ren_a);
    end
    tick(); idle();
    tick();
    @(negedge clk);
    checks++;
    if ({mdr_valid, mdr} !== {1'b1, ref_mem[3]}) begin
      errors++; $display("FAIL midrst_read: got %h expected %h", {mdr_valid, mdr}, {1'b1, ref_mem[3]});
    end
  endtask

  task automatic test_random();
    int a_issue, b_issue;
    logic [DATA_W-1:0] a_val, b_val, m_mdr;
    logic [MBR_W-1:0] m_mbr;
    logic a_wait, b_wait, e_wen, e_ren, e_renb, err, exp_err;
    logic [61:0] obs, expv;
    tick(); idle(); rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    a_issue = -10; b_issue = -10; a_val = '0; b_val = '0;
    m_mdr = '0; m_mbr = '0; exp_err = 1'b0;
    for (int n = 0; n < 400; n++) begin
      tick();
      rd       = ($urandom_range(0, 99) < 45);
      wr       = ($urandom_range(0, 99) < 20);
      fetch    = ($urandom_range(0, 99) < 45);
      mdr_load = ($urandom_range(0, 99) < 20);
      mar      = 9'($urandom_range(0, 15));
      pc       = 9'($urandom_range(0, 511));
      mdr_d    = 9'($urandom);
      a_wait = (n == a_issue + 1);
      b_wait = (n == b_issue + 1);
      e_wen  = wr && !a_wait;
      e_ren  = rd && !wr && !a_wait;
      e_renb = fetch && !b_wait;
      @(negedge clk);
      obs  = {mem_wen_a, mem_ren_a, mem_ren_b, mem_addr_a, mem_wdata_a, mem_addr_b,
              busy_a, busy_b, mdr_valid, mbr_valid, cmd_err, mdr, mbr_u, mbr_s};
      expv = {e_wen, e_ren, e_renb, mar, m_mdr, pc,
              a_wait, b_wait, (n == a_issue + 2), (n == b_issue + 2), exp_err,
              m_mdr, {1'b0, m_mbr}, {m_mbr[MBR_W-1], m_mbr}};
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL random_cycle%0d: got %h expected %h", n, obs, expv);
      end
      err = (rd && wr && !a_wait) || (a_wait && (rd || wr || mdr_load)) || (b_wait && fetch);
      if (e_ren) begin a_val = ref_mem[mar]; a_issue = n; end
      if (e_renb) begin b_val = ref_mem[pc]; b_issue = n; end
      if (e_wen) ref_mem[mar] = m_mdr;
      if (a_wait) m_mdr = a_val;
      else if (mdr_load) m_mdr = mdr_d;
      if (b_wait) m_mbr = b_val[MBR_W-1:0];
      exp_err = err;
    end
    tick(); idle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read();
    test_fetch();
    test_write_read();
    test_collisions();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-access controller between the MIC-1 datapath and the dual-port main memory.
- Port A carries MAR/MDR data reads and writes; port B carries PC/MBR instruction fetches.
- Turns single-cycle datapath strobes (rd, wr, fetch) into memory-port enables.
- Captures registered memory read data into its own MDR and MBR registers, tracks outstanding accesses and flags illegal command sequences.

Parameters:
- ADDR_W, 9, memory address width (MAR, PC, both memory address ports)
- DATA_W, 9, memory word width (MDR, memory data ports, extended MBR outputs)
- MBR_W, 8, instruction-byte width taken from the low bits of port-B read data

Ports:
- clk  in  1  single system clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd  in  1  datapath data-read strobe, one cycle
- wr  in  1  datapath data-write strobe, one cycle; writes the current MDR
- fetch  in  1  datapath instruction-fetch strobe, one cycle
- mar  in  ADDR_W  data address, sampled with rd/wr
- pc  in  ADDR_W  fetch address, sampled with fetch
- mdr_load  in  1  datapath load of MDR from mdr_d
- mdr_d  in  DATA_W  datapath value for MDR
- mdr  out  DATA_W  MDR register
- mbr_u  out  DATA_W  MBR zero-extended to DATA_W
- mbr_s  out  DATA_W  MBR sign-extended from bit MBR_W-1
- mdr_valid  out  1  one-cycle pulse in the cycle MDR first shows read data
- mbr_valid  out  1  one-cycle pulse in the cycle MBR first shows fetched data
- busy_a  out  1  port-A read outstanding
- busy_b  out  1  port-B fetch outstanding
- cmd_err  out  1  one-cycle pulse on an illegal command
- mem_wen_a  out  1  to memory port-A write enable
- mem_ren_a  out  1  to memory port-A read enable
- mem_addr_a  out  ADDR_W  to memory port-A address
- mem_wdata_a  out  DATA_W  to memory port-A write data
- mem_rdata_a  in  DATA_W  from memory port-A registered read data
- mem_ren_b  out  1  to memory port-B read enable
- mem_addr_b  out  ADDR_W  to memory port-B address
- mem_rdata_b  in  DATA_W  from memory port-B registered read data

Behaviour:
- Reset (rst_n low, asynchronous):
  - mdr, MBR, mdr_valid, mbr_valid, busy_a, busy_b, cmd_err clear to 0; both FSMs go to IDLE.
  - mem_wen_a, mem_ren_a and mem_ren_b are forced 0 combinationally while rst_n is low.
- Memory ports are the same-cycle combinational image of accepted commands:
  - mem_addr_a = mar; mem_wdata_a = mdr; mem_addr_b = pc.
  - The memory samples the command at the end of issue cycle N; its rdata is valid during N+1.
- Port-A FSM, states IDLE -> RD_WAIT -> CAPTURE -> IDLE:
  - IDLE, rd only: mem_ren_a=1 in N; next state RD_WAIT.
  - IDLE, wr only: mem_wen_a=1 in N; write completes at the N edge; stay IDLE, so port A is free at N+1.
  - IDLE, rd and wr together: write performed, read dropped, cmd_err pulses in N+1.
  - RD_WAIT (cycle N+1): busy_a=1; mdr <= mem_rdata_a at the end of N+1; next state CAPTURE.
  - CAPTURE (cycle N+2): busy_a=0, mdr_valid=1; a new rd/wr is accepted in this cycle; next state IDLE or RD_WAIT.
  - rd or wr arriving in RD_WAIT: ignored (no memory enable), cmd_err pulses next cycle.
- Port-B FSM: identical structure driven by fetch and pc.
  - MBR <= mem_rdata_b[MBR_W-1:0] at the end of N+1.
  - busy_b=1 in N+1; mbr_valid=1 in N+2.
  - fetch during busy_b: ignored, cmd_err.
- Ports A and B are fully independent; rd, wr and fetch may coincide freely across the two ports.
- MDR write conflict:
  - mdr_load outside a capture edge: mdr <= mdr_d.
  - mdr_load on the same edge as a read capture: capture wins, load dropped, cmd_err.
- Write data is the MDR value in cycle N, including any value loaded by mdr_load on the edge before N.
- Extension: mbr_u = zero-extend(MBR); mbr_s = replicate MBR[MBR_W-1] into the upper DATA_W-MBR_W bits.
- cmd_err is registered: exactly one cycle wide per offending cycle, regardless of how many errors occur in that cycle.
- rst_n asserted mid-read: the access is abandoned, no valid pulse, FSM returns to IDLE. After release, the first command behaves as from IDLE.
- No address range check: out-of-range addresses pass through unchanged.

Test Plan:
- Read: memory[3]=0x1A5; rd, mar=3 in cycle N -> mem_ren_a=1 and mem_addr_a=3 in N; busy_a=1 in N+1; mdr=0x1A5 with mdr_valid=1 in N+2.
- Fetch with extension: memory[5]=0x0F0; fetch, pc=5 -> mbr_valid in N+2, mbr_u=0x0F0, mbr_s=0x1F0. Repeat with 0x07F -> both outputs 0x07F.
- Write then read back: mdr_load with 0x123, then wr with mar=7, then rd with mar=7 -> mem_wen_a=1 with wdata 0x123; mdr=0x123 two cycles after the rd.
- Collisions:
  - rd+wr same cycle -> write occurs, no mem_ren_a, cmd_err one cycle later.
  - rd in RD_WAIT -> no mem_ren_a, cmd_err.
  - mdr_load on the capture edge -> mdr holds read data, cmd_err.
- Concurrency and back-to-back: rd and fetch in the same cycle -> both complete in N+2 independently; rd repeated in each CAPTURE cycle -> one result every 2 cycles, no cmd_err.
- Reset mid-operation: rst_n low during RD_WAIT -> all outputs 0 immediately, no mdr_valid; after release a fresh rd returns correct data in N+2.
